data_memory_lsu: RTL
====================

Name: data_memory_lsu

Overview:
Parametrised, byte-addressable data memory with load/store sizing for the single-cycle/multicycle CPU datapath. It supports byte, halfword and word accesses, with sign or zero extension on loads. Requests use a valid/ready handshake and responses arrive with a fixed one-cycle latency. Misaligned, out-of-range and illegal-size accesses are flagged as faults. After reset the block runs a sequential clear phase before it accepts traffic.

Parameters:
DEPTH, 64, number of 32-bit words; must be a power of two, minimum 4
ADDR_W, 32, width of the byte address
IDX_W, $clog2(DEPTH), word-index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle pulse, response for the accepted request
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_fault  out  1  accepted request faulted; no memory write occurred
init_done  out  1  clear phase complete
fault_count  out  16  saturating count of faulted requests

Behaviour:
- Reset (async, rst=1): state=INIT, clear counter=0. req_ready=0, resp_valid=0, resp_rdata=0, resp_fault=0, init_done=0, fault_count=0.
- INIT state:
  - One word is written to 0 per cycle, at index = counter.
  - After DEPTH cycles, transition to RUN and set init_done=1; it stays 1 until the next reset.
  - req_valid is ignored while in INIT.
- RUN state:
  - req_ready=1 every cycle; there is no response backpressure.
  - A request is accepted when req_valid && req_ready. Accepted requests are pipelined back-to-back, one per cycle.
- Address decode:
  - word index = req_addr[IDX_W+1:2]
  - byte lane = req_addr[1:0]
- Fault conditions (any one makes the request a fault):
  - req_size==11
  - halfword with req_addr[0]=1
  - word with req_addr[1:0]!=0
  - req_addr >= DEPTH*4
- Faulted request: memory is unchanged. The next cycle gives resp_valid=1, resp_fault=1, resp_rdata=0. fault_count increments and saturates at 16'hFFFF.
- Store (no fault):
  - Writes only the addressed lanes on the accepting edge.
  - Byte: lane = addr[1:0]. Half: lanes {addr[1],0} and {addr[1],1}. Word: all 4 lanes.
  - Data is taken from req_wdata[7:0] / [15:0] / [31:0], shifted to the lane.
  - Next cycle: resp_valid=1, resp_fault=0, resp_rdata=0.
- Load (no fault):
  - Memory word is read at the accepting edge, selected lanes are extracted, and the result is extended per req_unsigned.
  - resp_valid=1 with the data in the following cycle (latency 1).
  - For word loads req_unsigned is ignored.
- Store then load to the same address in consecutive cycles: the load returns the newly stored data. Same-edge ordering holds because there is one request per cycle.
- No request accepted: resp_valid=0; resp_rdata and resp_fault hold 0.
- Reset mid-operation:
  - Any in-flight response is dropped: resp_valid goes to 0 immediately (async).
  - Memory is re-cleared by a fresh INIT phase.
  - fault_count returns to 0.
- Simultaneous rst and req_valid: reset wins and the request is discarded.

Test Plan:
- Release rst, hold req_valid=1 -> req_ready=0 and init_done=0 for exactly 64 cycles (DEPTH=64); then init_done=1, req_ready=1. Word load of addr 0x3C -> 0x00000000.
- Word store 0x80F0_1234 @0x44, then byte load @0x47 signed -> 0xFFFFFF80; unsigned -> 0x00000080; half load @0x44 signed -> 0x00001234.
- Byte store 0xAB @0x45 over 0x80F0_1234 -> word load @0x44 returns 0x80F0_AB34 (other lanes preserved).
- Half load @0x43, word store @0x42, req_size=11, load @0x100 (DEPTH=64) -> each gives resp_fault=1, resp_rdata=0, memory unchanged, fault_count=4.
- Back-to-back: store 0x11 @0x10 then word load @0x10 the next cycle -> resp_valid on consecutive cycles; load returns 0x00000011.
- Assert rst while a load response is pending -> resp_valid=0 at once; after a full re-init, load of the previously written address returns 0, fault_count=0.

Source files
------------

// File: rtl/data_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_lsu
// Description : Byte-addressable data memory with load/store sizing, sign/zero
//               extension, valid/ready request handshake, fixed 1-cycle
//               response latency, fault detection and a post-reset clear phase.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_lsu #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              init_done,
  output logic [15:0]       fault_count
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  localparam logic [ADDR_W-1:0] c_ADDR_LIMIT = ADDR_W'(DEPTH * 4);

  logic [31:0]      r_mem [DEPTH];
  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_clr_idx;
  logic             r_init_done;
  logic [15:0]      r_fault_count;
  logic             r_resp_valid;
  logic             r_resp_fault;
  logic [31:0]      r_resp_rdata;

  logic             w_accept;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic             w_fault;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_sh;
  logic [31:0]      w_rd_word;
  logic [31:0]      w_rd_shifted;
  logic [31:0]      w_load_data;

  assign req_ready   = (r_state == S_RUN);
  assign w_accept    = req_valid && req_ready;
  assign w_idx       = req_addr[IDX_W+1:2];
  assign w_lane      = req_addr[1:0];

  // Any illegal size, misalignment or out-of-range address faults the request
  always_comb begin
    w_fault = 1'b0;
    if (req_size == 2'b11)                         w_fault = 1'b1;
    if (req_size == c_SZ_HALF && req_addr[0])      w_fault = 1'b1;
    if (req_size == c_SZ_WORD && w_lane != 2'b00)  w_fault = 1'b1;
    if (req_addr >= c_ADDR_LIMIT)                  w_fault = 1'b1;
  end

  // Lane enables and lane-aligned store data
  always_comb begin
    w_wdata_sh = req_wdata << {w_lane, 3'b000};
    case (req_size)
      c_SZ_BYTE: w_be = 4'b0001 << w_lane;
      c_SZ_HALF: w_be = 4'b0011 << w_lane;
      default:   w_be = 4'b1111;
    endcase
  end

  // Load path: pick the addressed lanes from the current word and extend them
  always_comb begin
    w_rd_word    = r_mem[w_idx];
    w_rd_shifted = w_rd_word >> {w_lane, 3'b000};
    case (req_size)
      c_SZ_BYTE: w_load_data = req_unsigned ? {24'h0, w_rd_shifted[7:0]}
                                            : {{24{w_rd_shifted[7]}}, w_rd_shifted[7:0]};
      c_SZ_HALF: w_load_data = req_unsigned ? {16'h0, w_rd_shifted[15:0]}
                                            : {{16{w_rd_shifted[15]}}, w_rd_shifted[15:0]};
      default:   w_load_data = w_rd_word;
    endcase
  end

  // Control FSM: sequential clear phase, then accept traffic until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_clr_idx   <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Memory array: clears one word per cycle in INIT, byte-enabled stores in RUN
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_clr_idx] <= 32'h0;
    end else if (w_accept && req_write && !w_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  // Response register: one-cycle pulse per accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_fault <= w_fault;
      r_resp_rdata <= (!req_write && !w_fault) ? w_load_data : 32'h0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= 32'h0;
    end
  end

  // Saturating count of faulted requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault_count <= 16'h0;
    end else if (w_accept && w_fault && r_fault_count != 16'hFFFF) begin
      r_fault_count <= r_fault_count + 16'h1;
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_fault  = r_resp_fault;
  assign resp_rdata  = r_resp_rdata;
  assign init_done   = r_init_done;
  assign fault_count = r_fault_count;

endmodule
`default_nettype wire
